miller_top: RTL and testbench

//  Byte-oriented Miller (delay-modulation) line codec: the TX path serializes bytes into a

---
 rtl/miller_top.sv | 190 +++++++++++++++++++
 tb/tb_miller_top.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/miller_top.sv
`default_nettype none
// ============================================================================
//  Module   : miller_top
//  Purpose  : Byte-oriented Miller (delay-modulation) line codec.
//             TX serializes bytes (start bit '1' + b7..b0) into a Miller
//             stream.  RX recovers bytes from a Miller stream by sampling
//             each bit at 1/4 and 3/4 of the bit period; a mid-bit
//             transition (s1 != s2) decodes as '1'.
//  Ports    : clk            - rising-edge clock
//             rst_p          - synchronous reset, active-low
//             data_in        - TX byte
//             data_in_valid  - TX byte valid
//             data_tready    - TX ready (IDLE only)
//             data_out       - last decoded RX byte
//             data_out_valid - one-cycle pulse when data_out updates
//             Miller_BitIn   - asynchronous serial input (2-FF synchronized)
//             Miller_BitOut  - registered serial output
//  Revision : 1.0  initial release
// ============================================================================
module miller_top #(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_tready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       Miller_BitIn,
    output logic       Miller_BitOut
);

    localparam int H  = HALF_BIT_CYCLES;
    localparam int CW = $clog2(4 * H);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_GUARD = 2'd2
    } tx_state_t;

    tx_state_t         tx_state_q;
    logic              tx_tready_q;
    logic              tx_line_q;
    logic [8:0]        tx_sr_q;     // [8] = bit on the line, [7] = next bit
    logic [3:0]        tx_bit_q;
    logic [CW-1:0]     tx_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_p) begin
            tx_state_q  <= TX_IDLE;
            tx_tready_q <= 1'b0;
            tx_line_q   <= 1'b0;
            tx_sr_q     <= '0;
            tx_bit_q    <= '0;
            tx_cnt_q    <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_tready_q <= 1'b1;
                    if (data_in_valid && tx_tready_q) begin
                        tx_tready_q <= 1'b0;
                        tx_sr_q     <= {1'b1, data_in};
                        tx_bit_q    <= '0;
                        tx_cnt_q    <= '0;
                        tx_state_q  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                    // '1' bits toggle at mid-bit
                    if (tx_cnt_q == CW'(H - 1) && tx_sr_q[8]) begin
                        tx_line_q <= ~tx_line_q;
                    end
                    if (tx_cnt_q == CW'(2 * H - 1)) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 4'd8) begin
                            tx_state_q <= TX_GUARD;
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                            tx_sr_q  <= {tx_sr_q[7:0], 1'b0};
                            // boundary toggle between two consecutive '0' bits
                            if (!tx_sr_q[8] && !tx_sr_q[7]) begin
                                tx_line_q <= ~tx_line_q;
                            end
                        end
                    end
                end
                TX_GUARD: begin
                    // line held static so the RX side is re-armed
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                    if (tx_cnt_q == CW'(4 * H - 1)) begin
                        tx_cnt_q    <= '0;
                        tx_tready_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign data_tready   = tx_tready_q;
    assign Miller_BitOut = tx_line_q;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    rx_state_t         rx_state_q;
    logic              rx_meta_q;
    logic              rx_sync_q;
    logic              rx_prev_q;
    logic [CW-1:0]     rx_cnt_q;
    logic [3:0]        rx_samp_q;   // even = first sample, odd = second
    logic              rx_s1_q;
    logic [7:0]        rx_sr_q;
    logic [7:0]        rx_data_q;
    logic              rx_valid_q;
    logic              rx_bit_d;

    assign rx_bit_d = rx_s1_q ^ rx_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_p) begin
            rx_state_q <= RX_IDLE;
            rx_meta_q  <= 1'b0;
            rx_sync_q  <= 1'b0;
            rx_prev_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_samp_q  <= '0;
            rx_s1_q    <= 1'b0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= Miller_BitIn;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    // first edge is the start bit's mid point (t0); first
                    // sample lands at t0 + H + H/2
                    if (rx_sync_q != rx_prev_q) begin
                        rx_cnt_q   <= CW'(3 * H / 2 - 1);
                        rx_samp_q  <= '0;
                        rx_state_q <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (rx_cnt_q == '0) begin
                        rx_cnt_q  <= CW'(H - 1);
                        rx_samp_q <= rx_samp_q + 1'b1;
                        if (!rx_samp_q[0]) begin
                            rx_s1_q <= rx_sync_q;
                        end else begin
                            rx_sr_q <= {rx_sr_q[6:0], rx_bit_d};
                        end
                        if (rx_samp_q == 4'd15) begin
                            rx_data_q  <= {rx_sr_q[6:0], rx_bit_d};
                            rx_valid_q <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign data_out       = rx_data_q;
    assign data_out_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_miller_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_miller_top
//  Purpose  : Directed self-checking bench for miller_top in loopback
//             (Miller_BitOut drives Miller_BitIn).
//  Revision : 1.0  initial release
// ============================================================================
module tb_miller_top;

    localparam int H = 4;

    logic       clk;
    logic       rst_p;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_tready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       bit_line;

    int n_total;
    int n_bad;
    logic [7:0] rxq[$];

    miller_top #(.HALF_BIT_CYCLES(H)) u_dut (
        .clk            (clk),
        .rst_p          (rst_p),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_tready    (data_tready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .Miller_BitIn   (bit_line),
        .Miller_BitOut  (bit_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_out_valid) rxq.push_back(data_out);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Presents one byte on the handshake; returns on the negedge right after
    // the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        while (data_tready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_eq("tready_wait", {31'd0, data_tready}, 32'd1);
        data_in       = b;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int w;
        w = 0;
        while (rxq.size() < n && w < 60 * H) begin
            @(negedge clk);
            w++;
        end
        check_eq("rx_count", rxq.size(), n);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // A5 = 1,1,0,1,0,0,1,0,1 (with start) starting from level 0
    logic exp_a5 [18] = '{0,1, 1,0, 0,0, 0,1, 1,1, 0,0, 0,1, 1,1, 1,0};

    logic [7:0] vec4 [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};

    initial begin
        int viol;
        int rx_before;
        n_total       = 0;
        n_bad         = 0;
        rst_p         = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;

        // 1: reset
        idle_cycles(3);
        check_eq("rst_tready", {31'd0, data_tready}, 32'd0);
        check_eq("rst_bitout", {31'd0, bit_line}, 32'd0);
        check_eq("rst_dout", {24'd0, data_out}, 32'h00);
        check_eq("rst_dvalid", {31'd0, data_out_valid}, 32'd0);
        rst_p = 1'b1;
        @(negedge clk);
        check_eq("tready_after_rst", {31'd0, data_tready}, 32'd1);

        // 6: long idle with valid low
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (data_tready !== 1'b1 || bit_line !== 1'b0 || data_out_valid !== 1'b0) viol++;
            @(negedge clk);
        end
        check_eq("idle_static", viol, 0);
        check_eq("idle_no_rx", rxq.size(), 0);

        // 2: waveform of 8'hA5
        send_byte(8'hA5);
        for (int k = 0; k < 18 * H; k++) begin
            if (k % H == 1) begin
                check_eq($sformatf("a5_half%0d", k / H), {31'd0, bit_line}, {31'd0, exp_a5[k / H]});
            end
            @(negedge clk);
        end
        wait_rx(1);
        if (rxq.size() >= 1) check_eq("a5_decode", {24'd0, rxq[0]}, 32'hA5);
        rxq.delete();

        // 3: streamed bytes 0..11
        for (int b = 0; b < 12; b++) send_byte(8'(b));
        wait_rx(12);
        idle_cycles(40 * H);
        check_eq("stream_count", rxq.size(), 12);
        for (int b = 0; b < 12; b++) begin
            if (b < rxq.size()) check_eq($sformatf("stream_%0d", b), {24'd0, rxq[b]}, b);
        end
        rxq.delete();

        // 4: boundary bytes
        for (int i = 0; i < 4; i++) send_byte(vec4[i]);
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            if (i < rxq.size()) check_eq($sformatf("bound_%0d", i), {24'd0, rxq[i]}, {24'd0, vec4[i]});
        end
        idle_cycles(30 * H);
        rxq.delete();

        // 5: reset mid-frame
        send_byte(8'hFF);
        idle_cycles(6 * H);
        rx_before = rxq.size();
        rst_p = 1'b0;
        idle_cycles(3);
        check_eq("midrst_bitout", {31'd0, bit_line}, 32'd0);
        check_eq("midrst_tready", {31'd0, data_tready}, 32'd0);
        check_eq("midrst_dout", {24'd0, data_out}, 32'h00);
        rst_p = 1'b1;
        idle_cycles(40 * H);
        check_eq("midrst_no_rx", rxq.size(), rx_before);
        send_byte(8'h3C);
        wait_rx(1);
        if (rxq.size() >= 1) check_eq("post_rst_3c", {24'd0, rxq[0]}, 32'h3C);
        idle_cycles(30 * H);
        check_eq("post_rst_count", rxq.size(), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
